// File: rtl/fetch_buffer_unit_pkg.sv
// fetch_buffer_unit_pkg: shared fetch widths, reset/step defaults and the queued entry type.
package fetch_buffer_unit_pkg;
    localparam int DEF_XLEN = 32;
    localparam int DEF_ILEN = 32;
    localparam int DEF_DEPTH = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int DEF_PC_STEP = 4;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_unit_if.sv
// fetch_buffer_unit_if: imem request/response, redirect and ID handshake bundle.
interface fetch_buffer_unit_if #(parameter int XLEN = 32, parameter int ILEN = 32);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [ILEN-1:0] id_inst;
    logic            id_ready;
    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_inst, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
        output imem_req_ready, imem_rsp_valid, imem_rsp_inst, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_buffer_unit_fifo.sv
// fetch_buffer_unit_fifo: pointer FIFO with wrap bit, synchronous flush, same-cycle push/pop.
module fetch_buffer_unit_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic wr_en, rd_en;
    always_comb begin
        count = wr_q - rd_q;
        empty = count == '0;
        rd_en = pop && !empty;
        // a full queue still accepts a push when the head leaves in the same cycle
        wr_en = push && (count != (AW+1)'(DEPTH) || rd_en);
        wr_d = flush ? '0 : wr_q + (AW+1)'(wr_en);
        rd_d = flush ? '0 : rd_q + (AW+1)'(rd_en);
        dout = mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        if (wr_en && !flush) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fetch_buffer_unit.sv
// fetch_buffer_unit: PC generator with credit-limited imem fetch, instruction queue toward ID
// and redirect flush that drops responses still in flight for the old path.
module fetch_buffer_unit
    import fetch_buffer_unit_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int ILEN = DEF_ILEN,
    parameter int DEPTH = DEF_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic                       clk,
    input  logic                       rst,
    fetch_buffer_unit_if.master        bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d, count;
    logic redirect, accept, push, pop, empty;
    logic [XLEN+ILEN-1:0] head;
    always_comb begin
        redirect = bus.redirect_valid;
        // credit: every outstanding request is guaranteed a queue slot
        bus.imem_req_valid = !rst && !redirect && ({1'b0, count} + {1'b0, inflight_q} < DEPTH_W);
        bus.imem_req_addr = fetch_pc_q;
        accept = bus.imem_req_valid && bus.imem_req_ready;
        push = bus.imem_rsp_valid && !redirect && drop_cnt_q == '0;
        bus.id_valid = !rst && !empty;
        {bus.id_pc, bus.id_inst} = rst ? '0 : head;
        occupancy = rst ? '0 : count;
        pop = bus.id_valid && bus.id_ready && !redirect;
        inflight_d = inflight_q + CW'(accept) - CW'(bus.imem_rsp_valid);
        drop_cnt_d = redirect ? inflight_q - CW'(bus.imem_rsp_valid)
                   : (bus.imem_rsp_valid && drop_cnt_q != '0) ? drop_cnt_q - CW'(1) : drop_cnt_q;
        fetch_pc_d = redirect ? bus.redirect_pc : accept ? fetch_pc_q + STEP : fetch_pc_q;
        rsp_pc_d = redirect ? bus.redirect_pc : push ? rsp_pc_q + STEP : rsp_pc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            assert (inflight_q <= CW'(DEPTH) && drop_cnt_q <= CW'(DEPTH));
        end
    end
    fetch_buffer_unit_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect),
        .push(push),
        .pop(pop),
        .din({rsp_pc_q, bus.imem_rsp_inst}),
        .dout(head),
        .empty(empty),
        .count(count)
    );
endmodule

// File: tb/tb_fetch_buffer_unit.sv
// tb_fetch_buffer_unit: directed stimulus with a queue scoreboard checked by a separate monitor.
module tb_fetch_buffer_unit;
    import fetch_buffer_unit_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] occupancy;
    int total = 0;
    int bad = 0;
    int lat = 1;
    int acc_cnt = 0;
    int cyc;
    logic stable;
    logic [2:0] sv = '0;
    logic [31:0] sa [3];
    fetch_entry_t exp_q [$];
    fetch_entry_t mon_e;

    fetch_buffer_unit_if bus();
    fetch_buffer_unit dut (.clk(clk), .rst(rst), .bus(bus), .occupancy(occupancy));

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // imem: in-order pipe, response lat cycles after accept
    always @(posedge clk) begin
        sv <= rst ? 3'b0 : {sv[1:0], bus.imem_req_valid && bus.imem_req_ready};
        sa[0] <= bus.imem_req_addr;
        sa[1] <= sa[0];
        sa[2] <= sa[1];
        acc_cnt <= rst ? 0 : acc_cnt + int'(bus.imem_req_valid && bus.imem_req_ready);
    end
    assign bus.imem_rsp_valid = sv[lat-1];
    assign bus.imem_rsp_inst = inst_of(sa[lat-1]);

    // monitor: a handshake in a redirect cycle is old path and consumed silently
    always @(negedge clk) begin
        if (!rst && !bus.redirect_valid && bus.id_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h want no entry", bus.id_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_pc", bus.id_pc, mon_e.pc);
                chk("sb_inst", bus.id_inst, mon_e.inst);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_stream(input logic [31:0] pc0, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc = pc0 + 32'(4 * i);
            e.inst = inst_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        lat = l;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_id_valid", 32'(bus.id_valid), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_id_pc", bus.id_pc, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = pc;
        exp_q.delete();
        step(1);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            @(posedge clk);
            cycles++;
        end
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d entries left want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b0;

        // sequential stream, fill latency and one entry per cycle
        do_reset(1);
        bus.id_ready = 1'b1;
        expect_stream(32'h0, 8);
        @(negedge clk) chk("t1_fill_c0", 32'(bus.id_valid), 0);
        @(negedge clk) chk("t1_fill_c1", 32'(bus.id_valid), 0);
        @(negedge clk) chk("t1_fill_c2", 32'(bus.id_valid), 1);
        drain(20, cyc);
        chk("t1_cycles", cyc, 8);

        // ID stall: credit caps requests at DEPTH, head held
        do_reset(1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2 && (bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1)) stable = 1'b0;
        end
        chk("t2_head_stable", 32'(stable), 1);
        chk("t2_requests", acc_cnt, 4);
        chk("t2_occupancy", 32'(occupancy), 4);
        chk("t2_req_valid", 32'(bus.imem_req_valid), 0);
        expect_stream(32'h0, 5);
        bus.id_ready = 1'b1;
        drain(20, cyc);

        // redirect with two requests in flight (3-cycle imem)
        do_reset(3);
        bus.id_ready = 1'b1;
        step(2);
        redirect(32'h0000_0100);
        expect_stream(32'h0000_0100, 4);
        drain(30, cyc);

        // redirect coinciding with a response and an ID pop
        do_reset(1);
        bus.id_ready = 1'b1;
        step(2);
        redirect(32'h0000_0180);
        expect_stream(32'h0000_0180, 4);
        @(negedge clk);
        chk("t4_occupancy", 32'(occupancy), 0);
        chk("t4_id_valid", 32'(bus.id_valid), 0);
        chk("t4_req_valid", 32'(bus.imem_req_valid), 1);
        chk("t4_req_addr", bus.imem_req_addr, 32'h0000_0180);
        @(negedge clk) chk("t4_id_valid_t2", 32'(bus.id_valid), 0);
        @(negedge clk);
        chk("t4_id_valid_t3", 32'(bus.id_valid), 1);
        chk("t4_id_pc_t3", bus.id_pc, 32'h0000_0180);
        drain(20, cyc);

        // back-to-back redirects with responses in flight
        do_reset(2);
        bus.id_ready = 1'b1;
        step(2);
        redirect(32'h0000_0200);
        redirect(32'h0000_0300);
        expect_stream(32'h0000_0300, 4);
        drain(30, cyc);

        // PC wrap, then reset in the middle of a stall
        do_reset(1);
        bus.id_ready = 1'b1;
        redirect(32'hFFFF_FFF8);
        expect_stream(32'hFFFF_FFF8, 4);
        drain(20, cyc);
        bus.id_ready = 1'b0;
        step(10);
        @(negedge clk);
        chk("t6_occupancy", 32'(occupancy), 4);
        chk("t6_head_pc", bus.id_pc, 32'h0000_0008);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t6_rst_occupancy", 32'(occupancy), 0);
        chk("t6_rst_id_valid", 32'(bus.id_valid), 0);
        chk("t6_rst_req_valid", 32'(bus.imem_req_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_post_req_valid", 32'(bus.imem_req_valid), 1);
        chk("t6_post_req_addr", bus.imem_req_addr, 32'(DEF_RESET_PC));
        chk("t6_post_occupancy", 32'(occupancy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
